// File: rtl/rf_io_ctrl_pkg.sv
// Shared definitions for the RF/digital I/O controller: register addresses,
// RF mode encoding and the mode-to-switch decode. Optional: RF_IO_CTRL_BUTTON_LATCH_EN.
package rf_io_ctrl_pkg;

  localparam logic [4:0] ADDR_VERSION  = 5'h01;
  localparam logic [4:0] ADDR_SYS      = 5'h02;
  localparam logic [4:0] ADDR_PMOD_DIR = 5'h03;
  localparam logic [4:0] ADDR_PMOD_VAL = 5'h04;
  localparam logic [4:0] ADDR_RF_CTRL  = 5'h05;
`ifdef RF_IO_CTRL_BUTTON_LATCH_EN
  localparam logic [4:0] ADDR_BTN_LATCH = 5'h06;
`endif

  typedef enum logic [2:0] {
    LOW_PWR    = 3'd0,
    RX_LOWPASS = 3'd1,
    RX_HIPASS  = 3'd2,
    BYPASS     = 3'd3,
    TX_LOWPASS = 3'd4,
    TX_HIPASS  = 3'd5
  } rf_mode_e;

  // Bit order: {rx_h_tx_l, vc1, vc2, shdn_rx, shdn_tx, mixer_en}
  function automatic logic [5:0] rf_switch_vec(input rf_mode_e mode);
    logic [5:0] vec;
    case (mode)
      RX_LOWPASS: vec = 6'b110011;
      RX_HIPASS:  vec = 6'b101011;
      BYPASS:     vec = 6'b100010;
      TX_LOWPASS: vec = 6'b010101;
      TX_HIPASS:  vec = 6'b001101;
      default:    vec = 6'b100110;
    endcase
    return vec;
  endfunction

  // Codes 6 and 7 have no defined switch setting, so they fall back to low power.
  function automatic rf_mode_e rf_mode_from_bits(input logic [2:0] bits);
    rf_mode_e mode;
    if (bits > 3'd5) begin
      mode = LOW_PWR;
    end else begin
      mode = rf_mode_e'(bits);
    end
    return mode;
  endfunction

endpackage

// File: rtl/rf_io_ctrl_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs (button, straps, PMOD pins).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_b,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      meta <= '0;
      o_q  <= '0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/rf_io_ctrl.sv
// Register-mapped LED/PMOD/RF front-end controller on the SPI command bus.
// Optional: RF_IO_CTRL_BUTTON_LATCH_EN adds a sticky button-press flag at 0x06.
module rf_io_ctrl
  import rf_io_ctrl_pkg::*;
#(
  parameter logic [7:0] VERSION = 8'h01
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic [4:0] i_ioc,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  input  logic       i_cs,
  input  logic       i_fetch_cmd,
  input  logic       i_load_cmd,
  input  logic       i_button,
  input  logic [3:0] i_config,
  input  logic [7:0] i_pmod_in,
  output logic [7:0] o_pmod_out,
  output logic [7:0] o_pmod_dir,
  output logic       o_led0,
  output logic       o_led1,
  output logic       o_rx_h_tx_l,
  output logic       o_rx_h_tx_l_b,
  output logic       o_tr_vc1,
  output logic       o_tr_vc1_b,
  output logic       o_tr_vc2,
  output logic       o_shdn_rx_lna,
  output logic       o_shdn_tx_lna,
  output logic       o_mixer_en,
  output logic       o_mixer_fm
);

  logic       button_sync;
  logic [3:0] config_sync;
  logic [7:0] pmod_in_sync;
  logic       write_en;
  logic       fetch_en;
  logic [7:0] read_val;
  logic       led0;
  logic       led1;
  logic [7:0] pmod_dir;
  logic [7:0] pmod_out;
  rf_mode_e   rf_mode;
  logic       mixer_fm;
  logic [5:0] switch_vec;

  sync_2ff #(.WIDTH(1)) u_sync_button (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .i_d       (i_button),
    .o_q       (button_sync)
  );

  sync_2ff #(.WIDTH(4)) u_sync_config (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .i_d       (i_config),
    .o_q       (config_sync)
  );

  sync_2ff #(.WIDTH(8)) u_sync_pmod (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .i_d       (i_pmod_in),
    .o_q       (pmod_in_sync)
  );

  assign write_en = i_cs & i_load_cmd;
  assign fetch_en = i_cs & i_fetch_cmd;

`ifdef RF_IO_CTRL_BUTTON_LATCH_EN
  logic button_prev;
  logic button_flag;
  logic button_rise;

  assign button_rise = button_sync & ~button_prev;

  // A press arriving on the same edge as the clearing fetch must not be lost.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      button_prev <= 1'b0;
      button_flag <= 1'b0;
    end else begin
      button_prev <= button_sync;
      if (button_rise) begin
        button_flag <= 1'b1;
      end else if (fetch_en && (i_ioc == ADDR_BTN_LATCH)) begin
        button_flag <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    read_val = 8'h00;
    case (i_ioc)
      ADDR_VERSION:   read_val = VERSION;
      ADDR_SYS:       read_val = {config_sync, 1'b0, button_sync, led1, led0};
      ADDR_PMOD_DIR:  read_val = pmod_dir;
      ADDR_PMOD_VAL:  read_val = pmod_in_sync;
      ADDR_RF_CTRL:   read_val = {4'b0000, mixer_fm, rf_mode};
`ifdef RF_IO_CTRL_BUTTON_LATCH_EN
      ADDR_BTN_LATCH: read_val = {7'b0000000, button_flag};
`endif
      default:        read_val = 8'h00;
    endcase
  end

  // Read data is taken from the pre-write register state, so a same-edge
  // load and fetch to one address returns the old value.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      o_data_out <= 8'h00;
    end else if (fetch_en) begin
      o_data_out <= read_val;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      led0     <= 1'b0;
      led1     <= 1'b0;
      pmod_dir <= 8'h00;
      pmod_out <= 8'h00;
      rf_mode  <= LOW_PWR;
      mixer_fm <= 1'b0;
    end else if (write_en) begin
      case (i_ioc)
        ADDR_SYS: begin
          led0 <= i_data_in[0];
          led1 <= i_data_in[1];
        end
        ADDR_PMOD_DIR: pmod_dir <= i_data_in;
        ADDR_PMOD_VAL: pmod_out <= i_data_in;
        ADDR_RF_CTRL: begin
          rf_mode  <= rf_mode_from_bits(i_data_in[2:0]);
          mixer_fm <= i_data_in[3];
        end
        default: ;
      endcase
    end
  end

  assign switch_vec = rf_switch_vec(rf_mode);

  assign o_rx_h_tx_l   = switch_vec[5];
  assign o_rx_h_tx_l_b = ~switch_vec[5];
  assign o_tr_vc1      = switch_vec[4];
  assign o_tr_vc1_b    = ~switch_vec[4];
  assign o_tr_vc2      = switch_vec[3];
  assign o_shdn_rx_lna = switch_vec[2];
  assign o_shdn_tx_lna = switch_vec[1];
  assign o_mixer_en    = switch_vec[0];
  assign o_mixer_fm    = mixer_fm;
  assign o_led0        = led0;
  assign o_led1        = led1;
  assign o_pmod_dir    = pmod_dir;
  assign o_pmod_out    = pmod_out;

endmodule

// File: tb/tb_rf_io_ctrl.sv
// Scoreboard bench for rf_io_ctrl: a behavioural model predicts every cycle's
// outputs and every fetch result; a monitor pops and compares them.
module tb_rf_io_ctrl;

  logic       i_sys_clk = 1'b0;
  logic       i_rst_b = 1'b0;
  logic [4:0] i_ioc = '0;
  logic [7:0] i_data_in = '0;
  logic [7:0] o_data_out;
  logic       i_cs = 1'b0;
  logic       i_fetch_cmd = 1'b0;
  logic       i_load_cmd = 1'b0;
  logic       i_button = 1'b0;
  logic [3:0] i_config = '0;
  logic [7:0] i_pmod_in = '0;
  logic [7:0] o_pmod_out;
  logic [7:0] o_pmod_dir;
  logic       o_led0, o_led1;
  logic       o_rx_h_tx_l, o_rx_h_tx_l_b;
  logic       o_tr_vc1, o_tr_vc1_b, o_tr_vc2;
  logic       o_shdn_rx_lna, o_shdn_tx_lna;
  logic       o_mixer_en, o_mixer_fm;

  always #5 i_sys_clk = ~i_sys_clk;

  rf_io_ctrl dut (
    .i_sys_clk     (i_sys_clk),
    .i_rst_b       (i_rst_b),
    .i_ioc         (i_ioc),
    .i_data_in     (i_data_in),
    .o_data_out    (o_data_out),
    .i_cs          (i_cs),
    .i_fetch_cmd   (i_fetch_cmd),
    .i_load_cmd    (i_load_cmd),
    .i_button      (i_button),
    .i_config      (i_config),
    .i_pmod_in     (i_pmod_in),
    .o_pmod_out    (o_pmod_out),
    .o_pmod_dir    (o_pmod_dir),
    .o_led0        (o_led0),
    .o_led1        (o_led1),
    .o_rx_h_tx_l   (o_rx_h_tx_l),
    .o_rx_h_tx_l_b (o_rx_h_tx_l_b),
    .o_tr_vc1      (o_tr_vc1),
    .o_tr_vc1_b    (o_tr_vc1_b),
    .o_tr_vc2      (o_tr_vc2),
    .o_shdn_rx_lna (o_shdn_rx_lna),
    .o_shdn_tx_lna (o_shdn_tx_lna),
    .o_mixer_en    (o_mixer_en),
    .o_mixer_fm    (o_mixer_fm)
  );

  int total = 0;
  int bad = 0;

  logic [26:0] expQ[$];
  logic [7:0]  readQ[$];

  // Reference model state
  logic       mLed0, mLed1, mFm, mFlag;
  logic [7:0] mDir, mOut;
  logic [2:0] mMode;
  logic [12:0] pinHist[$];
  logic       curButton = 1'b0;
  logic [3:0] curCfg = '0;
  logic [7:0] curPmod = '0;

  // {rx_h_tx_l, vc1, vc2, shdn_rx, shdn_tx, mixer_en} per mode, straight from the mode table
  logic [5:0] swTable [6] = '{6'b100110, 6'b110011, 6'b101011, 6'b100010, 6'b010101, 6'b001101};
  logic [4:0] addrList [10] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h1F, 5'h10};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] expVec();
    logic [5:0] sw;
    sw = swTable[mMode];
    return {mLed0, mLed1, mDir, mOut, sw[5], ~sw[5], sw[4], ~sw[4], sw[3], sw[2], sw[1], sw[0], mFm};
  endfunction

  function automatic logic [26:0] actVec();
    return {o_led0, o_led1, o_pmod_dir, o_pmod_out, o_rx_h_tx_l, o_rx_h_tx_l_b, o_tr_vc1,
            o_tr_vc1_b, o_tr_vc2, o_shdn_rx_lna, o_shdn_tx_lna, o_mixer_en, o_mixer_fm};
  endfunction

  // Synchronized pins seen at an edge are the pins driven two edges earlier.
  function automatic logic [7:0] modelRead(input logic [4:0] ioc);
    logic [12:0] h;
    logic [7:0] r;
    h = pinHist[pinHist.size() - 3];
    r = 8'h00;
    case (ioc)
      5'h01: r = 8'h01;
      5'h02: r = {h[11:8], 1'b0, h[12], mLed1, mLed0};
      5'h03: r = mDir;
      5'h04: r = h[7:0];
      5'h05: r = {4'b0000, mFm, mMode};
`ifdef RF_IO_CTRL_BUTTON_LATCH_EN
      5'h06: r = {7'b0000000, mFlag};
`endif
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic resetModel();
    mLed0 = 0; mLed1 = 0; mFm = 0; mFlag = 0;
    mDir = 0; mOut = 0; mMode = 0;
    pinHist.delete();
    repeat (3) pinHist.push_back(13'h0);
  endtask

  task automatic applyStimulus(input logic cs, input logic fetch, input logic load,
                               input logic [4:0] ioc, input logic [7:0] data);
    logic rise;
    @(negedge i_sys_clk);
    i_cs = cs; i_fetch_cmd = fetch; i_load_cmd = load; i_ioc = ioc; i_data_in = data;
    i_button = curButton; i_config = curCfg; i_pmod_in = curPmod;
    pinHist.push_back({curButton, curCfg, curPmod});
    if (cs && fetch) readQ.push_back(modelRead(ioc));
    rise = pinHist[pinHist.size() - 3][12] & ~pinHist[pinHist.size() - 4][12];
    if (rise) mFlag = 1'b1;
    else if (cs && fetch && ioc == 5'h06) mFlag = 1'b0;
    if (cs && load) begin
      case (ioc)
        5'h02: begin mLed0 = data[0]; mLed1 = data[1]; end
        5'h03: mDir = data;
        5'h04: mOut = data;
        5'h05: begin mMode = (data[2:0] > 3'd5) ? 3'd0 : data[2:0]; mFm = data[3]; end
        default: ;
      endcase
    end
    if (pinHist.size() > 8) void'(pinHist.pop_front());
    expQ.push_back(expVec());
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 5'h00, 8'h00);
  endtask

  task automatic drainQueues();
    int k;
    k = 0;
    while ((expQ.size() != 0 || readQ.size() != 0) && k < 20) begin
      @(negedge i_sys_clk);
      k++;
    end
    if (expQ.size() != 0 || readQ.size() != 0) begin
      checkOutput("queue_drain", expQ.size() + readQ.size(), 0);
      expQ.delete();
      readQ.delete();
    end
  endtask

  task automatic releaseReset();
    @(posedge i_sys_clk);
    #1;
    i_rst_b = 1'b1;
    resetModel();
  endtask

  // Monitor: compares every modelled cycle and every fetch result.
  initial begin
    logic fetchSeen;
    forever begin
      @(posedge i_sys_clk);
      fetchSeen = i_cs & i_fetch_cmd & i_rst_b;
      #1;
      if (expQ.size() != 0) checkOutput("outputs", actVec(), expQ.pop_front());
      if (fetchSeen) begin
        if (readQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL read_underflow: got fetch with empty scoreboard at %0t", $time);
        end else begin
          checkOutput("data_out", o_data_out, readQ.pop_front());
        end
      end
    end
  end

  initial begin
    resetModel();
    #12;
    checkOutput("reset_data_out", o_data_out, 8'h00);
    checkOutput("reset_outputs", actVec(), expVec());
    releaseReset();

    $display("[TB] version and reset decode");
    applyStimulus(1, 1, 0, 5'h01, 8'h00);
    idle(1);

    $display("[TB] rf control");
    applyStimulus(1, 0, 1, 5'h05, 8'h0C);
    applyStimulus(1, 1, 0, 5'h05, 8'h00);
    applyStimulus(1, 0, 1, 5'h05, 8'h07);
    applyStimulus(1, 1, 0, 5'h05, 8'h00);
    idle(1);

    $display("[TB] sys register");
    curCfg = 4'hA; curButton = 1'b1;
    applyStimulus(1, 0, 1, 5'h02, 8'h03);
    idle(2);
    applyStimulus(1, 1, 0, 5'h02, 8'h00);
    curButton = 1'b0;

    $display("[TB] pmod");
    curPmod = 8'h3C;
    applyStimulus(1, 0, 1, 5'h03, 8'hF0);
    applyStimulus(1, 0, 1, 5'h04, 8'h5A);
    idle(1);
    applyStimulus(1, 1, 0, 5'h04, 8'h00);
    applyStimulus(1, 1, 0, 5'h03, 8'h00);

    $display("[TB] select, unmapped, read-only, same-cycle access");
    applyStimulus(0, 0, 1, 5'h04, 8'hFF);
    applyStimulus(0, 1, 0, 5'h01, 8'h00);
    applyStimulus(1, 1, 0, 5'h1F, 8'h00);
    applyStimulus(1, 0, 1, 5'h01, 8'h77);
    applyStimulus(1, 0, 1, 5'h07, 8'h55);
    applyStimulus(1, 1, 0, 5'h01, 8'h00);
    applyStimulus(1, 1, 1, 5'h02, 8'h01);
    applyStimulus(1, 1, 0, 5'h02, 8'h00);
    applyStimulus(1, 0, 1, 5'h05, 8'h0D);
    applyStimulus(1, 1, 0, 5'h01, 8'h00);
    idle(1);

    $display("[TB] asynchronous reset mid-sequence");
    drainQueues();
    @(negedge i_sys_clk);
    #2;
    i_rst_b = 1'b0;
    resetModel();
    #1;
    checkOutput("midreset_data_out", o_data_out, 8'h00);
    checkOutput("midreset_outputs", actVec(), expVec());
    releaseReset();

`ifdef RF_IO_CTRL_BUTTON_LATCH_EN
    $display("[TB] button latch");
    idle(3);
    curButton = 1'b1;
    idle(1);
    curButton = 1'b0;
    idle(3);
    applyStimulus(1, 1, 0, 5'h06, 8'h00);
    applyStimulus(1, 1, 0, 5'h06, 8'h00);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) curButton = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) curCfg = 4'($urandom);
      if ($urandom_range(0, 3) == 0) curPmod = 8'($urandom);
      applyStimulus($urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                    addrList[$urandom_range(0, 9)], 8'($urandom));
    end
    idle(2);
    drainQueues();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
